frame_rasterizer: RTL

- Write-side producer for the VGA frame buffer; clocked at 33 MHz.
- Holds a small table of filled rectangles.
- On each frame swap it sweeps the whole 1280x300 frame region and emits one (write_x, write_y, write_palette) per cycle. Every pixel gets a nonzero palette, so stale buffer content is always overwritten.
- Sits between the game/draw logic (command port) and the VGA block's write inputs; uses the VGA block's rst_screen_33m as its frame trigger.

---
 rtl/frame_rasterizer_if.sv | 31 +++
 rtl/frame_rasterizer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/frame_rasterizer_if.sv
// Command and pixel-write bundle between the draw logic, the rasterizer and the VGA write port.
// slave = rasterizer side, master = draw logic / frame buffer side.
interface frame_rasterizer_if #(
    parameter int COOR_WIDTH = 11,
    parameter int IDX_W      = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [IDX_W-1:0]      cmd_index;
    logic [COOR_WIDTH-1:0] cmd_x0;
    logic [COOR_WIDTH-1:0] cmd_y0;
    logic [COOR_WIDTH-1:0] cmd_x1;
    logic [COOR_WIDTH-1:0] cmd_y1;
    logic [1:0]            cmd_palette;
    logic [COOR_WIDTH-1:0] write_x;
    logic [COOR_WIDTH-1:0] write_y;
    logic [1:0]            write_palette;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;

    modport master (
        output cmd_valid, cmd_index, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_palette,
        input  cmd_ready, write_x, write_y, write_palette, busy, frame_done, overrun
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_palette,
        output cmd_ready, write_x, write_y, write_palette, busy, frame_done, overrun
    );
endinterface

// File: rtl/frame_rasterizer.sv
// Sweeps the frame once per frame_start pulse, painting a small rectangle table over a background.
// Optional macro RASTER_CHECKER_EN: uncovered pixels show an 8x8 checkerboard for alignment debug.
module frame_rasterizer #(
    parameter int         COOR_WIDTH = 11,
    parameter int         FRAME_W    = 1280,
    parameter int         FRAME_H    = 300,
    parameter int         NUM_RECTS  = 4,
    parameter int         IDX_W      = $clog2(NUM_RECTS),
    parameter logic [1:0] BG_PALETTE = 2'd1
) (
    input  logic                 clk_33m,
    input  logic                 rst_n,
    input  logic                 frame_start,
    frame_rasterizer_if.slave    bus
);
    localparam logic [COOR_WIDTH-1:0] X_LAST = COOR_WIDTH'(FRAME_W - 1);
    localparam logic [COOR_WIDTH-1:0] Y_LAST = COOR_WIDTH'(FRAME_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SWEEP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q;
    logic                  fs_q;
    logic [COOR_WIDTH-1:0] cx_q;
    logic [COOR_WIDTH-1:0] cy_q;
    logic                  cmd_ready_q;
    logic [COOR_WIDTH-1:0] write_x_q;
    logic [COOR_WIDTH-1:0] write_y_q;
    logic [1:0]            write_palette_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  overrun_q;

    logic [COOR_WIDTH-1:0] sh_x0_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] sh_y0_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] sh_x1_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] sh_y1_q  [NUM_RECTS];
    logic [1:0]            sh_pal_q [NUM_RECTS];
    logic [COOR_WIDTH-1:0] act_x0_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] act_y0_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] act_x1_q  [NUM_RECTS];
    logic [COOR_WIDTH-1:0] act_y1_q  [NUM_RECTS];
    logic [1:0]            act_pal_q [NUM_RECTS];

    logic                  rise_s;
    logic                  fall_s;
    logic                  cmd_accept_s;
    logic [1:0]            bg_s;
    logic [1:0]            pix_s;

    assign rise_s       = frame_start & ~fs_q;
    assign fall_s       = ~frame_start & fs_q;
    assign cmd_accept_s = bus.cmd_valid & cmd_ready_q;

    // Background colour for the pixel currently addressed by the counters.
    always_comb begin
        bg_s = BG_PALETTE;
`ifdef RASTER_CHECKER_EN
        bg_s = (cx_q[3] ^ cy_q[3]) ? 2'd2 : BG_PALETTE;
`else
        bg_s = BG_PALETTE;
`endif
    end

    // Rectangle hit test; later entries overwrite earlier ones so the highest index wins.
    always_comb begin
        pix_s = bg_s;
        for (int i = 0; i < NUM_RECTS; i++) begin
            pix_s = ((act_pal_q[i] != 2'd0) &&
                     (cx_q >= act_x0_q[i]) && (cx_q < act_x1_q[i]) &&
                     (cy_q >= act_y0_q[i]) && (cy_q < act_y1_q[i])) ? act_pal_q[i] : pix_s;
        end
    end

    // Frame FSM, rectangle tables, sweep counters and registered outputs.
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            fs_q            <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            cmd_ready_q     <= 1'b1;
            write_x_q       <= '0;
            write_y_q       <= '0;
            write_palette_q <= 2'd0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            overrun_q       <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                sh_x0_q[i]   <= '0;
                sh_y0_q[i]   <= '0;
                sh_x1_q[i]   <= '0;
                sh_y1_q[i]   <= '0;
                sh_pal_q[i]  <= 2'd0;
                act_x0_q[i]  <= '0;
                act_y0_q[i]  <= '0;
                act_x1_q[i]  <= '0;
                act_y1_q[i]  <= '0;
                act_pal_q[i] <= 2'd0;
            end
        end else begin
            fs_q            <= frame_start;
            write_palette_q <= 2'd0;
            frame_done_q    <= 1'b0;

            if (cmd_accept_s) begin
                sh_x0_q[bus.cmd_index]  <= bus.cmd_x0;
                sh_y0_q[bus.cmd_index]  <= bus.cmd_y0;
                sh_x1_q[bus.cmd_index]  <= bus.cmd_x1;
                sh_y1_q[bus.cmd_index]  <= bus.cmd_y1;
                sh_pal_q[bus.cmd_index] <= bus.cmd_palette;
            end else begin
                sh_pal_q <= sh_pal_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // The VGA block gates writes while frame_start is high, so hold off until it drops.
                    if (fall_s) begin
                        state_q     <= ST_LATCH;
                        cmd_ready_q <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_LATCH: begin
                    act_x0_q    <= sh_x0_q;
                    act_y0_q    <= sh_y0_q;
                    act_x1_q    <= sh_x1_q;
                    act_y1_q    <= sh_y1_q;
                    act_pal_q   <= sh_pal_q;
                    cx_q        <= '0;
                    cy_q        <= '0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (rise_s) begin
                        overrun_q <= 1'b1;
                        state_q   <= ST_WAIT;
                    end else begin
                        write_x_q       <= cx_q;
                        write_y_q       <= cy_q;
                        write_palette_q <= pix_s;
                        if (cx_q == X_LAST) begin
                            cx_q <= '0;
                            if (cy_q == Y_LAST) begin
                                cy_q         <= '0;
                                frame_done_q <= 1'b1;
                                state_q      <= ST_DONE;
                            end else begin
                                cy_q <= cy_q + 1'b1;
                            end
                        end else begin
                            cx_q <= cx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rise_s) begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.write_x       = write_x_q;
    assign bus.write_y       = write_y_q;
    assign bus.write_palette = write_palette_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.overrun       = overrun_q;
endmodule
